// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus carry flop, valid/ready on both sides.
// Define SUB_MODE_EN to add the op_sub port (a - b - cin with borrow-in/borrow-out).
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_MODE_EN
  input  logic             op_sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              sub_in, sub_q;
  logic              fa_sum, fa_carry;

`ifdef SUB_MODE_EN
  logic sub_d;
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  assign fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SUB_MODE_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          // Subtraction is a + ~b + ~cin; the inversion happens once at load time.
          a_sh_d  = a;
          b_sh_d  = b ^ {WIDTH{sub_in}};
          carry_d = cin ^ sub_in;
          count_d = '0;
`ifdef SUB_MODE_EN
          sub_d   = sub_in;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_carry;
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_carry ^ sub_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (done_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign start_ready = (state_q == StIdle);
  assign done_valid  = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed, random, backpressure and abort scenarios.
module tb_bit_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start_valid, start_ready, cin, cout, done_valid, done_ready, busy;
  logic         op_sub_drv;
  logic [W-1:0] a, b, sum;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SUB_MODE_EN
    .op_sub      (op_sub_drv),
`endif
    .sum         (sum),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  // Reference: plain (W+1)-bit arithmetic; the top bit is carry-out or borrow-out.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    if (ms) return {1'b0, ma} - {1'b0, mb} - (W + 1)'(mc);
    else    return {1'b0, ma} + {1'b0, mb} + (W + 1)'(mc);
  endfunction

  task automatic wait_ready();
    int cyc = 0;
    while (!start_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  // Handshake one operation, check latency and result, release after `hold` stall cycles.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W:0] exp, input int hold,
                        input string name);
    int cyc;
    wait_ready();
    a = ta; b = tb_v; cin = tc; op_sub_drv = ts; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 4 * W) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc != W + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, W + 1);
    end
    n_vec++;
    if ({cout, sum} !== exp) begin
      n_err++;
      $display("FAIL %s result: got cout=%b sum=%h, expected cout=%b sum=%h",
               name, cout, sum, exp[W], exp[W-1:0]);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    n_vec++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got done_valid=%b start_ready=%b, expected 0/1",
               name, done_valid, start_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if ({start_ready, done_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b dv=%b busy=%b cout=%b sum=%h, expected 1/0/0/0/00",
               start_ready, done_valid, busy, cout, sum);
    end
  endtask

  task automatic test_directed();
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 9'h07F, 0, "add_35_4a");
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 9'h101, 1, "add_ff_01_c");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0, "add_ff_ff_c");
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 0, "add_zero");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, one_hot;
    logic         rc, rs;
    for (int i = 0; i < 256; i++) begin
      one_hot = 8'h01 << (i % 8);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      case (i % 4)
        1: begin ra = 8'hFF; rb = one_hot; end
        2: begin ra = ~one_hot; rb = one_hot; end
        3: rb = ~ra;
        default: ;
      endcase
`ifdef SUB_MODE_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp1, exp2;
    int cyc;
    exp1 = model(8'h12, 8'h34, 1'b1, 1'b0);
    exp2 = model(8'h81, 8'h7F, 1'b0, 1'b0);
    wait_ready();
    a = 8'h12; b = 8'h34; cin = 1'b1; op_sub_drv = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 4 * W) begin
      @(posedge clk); #1; cyc++;
    end
    a = 8'h81; b = 8'h7F; cin = 1'b0; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({start_ready, done_valid, cout, sum} !== {1'b0, 1'b1, exp1}) begin
        n_err++;
        $display("FAIL backpressure hold %0d: got rdy=%b dv=%b cout=%b sum=%h, expected 0/1/%h",
                 i, start_ready, done_valid, cout, sum, exp1);
      end
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    n_vec++;
    if ({start_ready, done_valid, cout, sum} !== {1'b1, 1'b0, exp1}) begin
      n_err++;
      $display("FAIL backpressure idle: got rdy=%b dv=%b cout=%b sum=%h, expected 1/0/%h",
               start_ready, done_valid, cout, sum, exp1);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_vec++;
    if ({busy, start_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure accept: got busy=%b rdy=%b, expected 1/0", busy, start_ready);
    end
    cyc = 1;
    while (!done_valid && cyc < 4 * W) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc != W + 1 || {cout, sum} !== exp2) begin
      n_err++;
      $display("FAIL backpressure second: got %0d cycles %h, expected %0d cycles %h",
               cyc, {cout, sum}, W + 1, exp2);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_abort();
    int seen = 0;
    run_op(8'h5A, 8'h21, 1'b0, 1'b0, 9'h07B, 0, "pre_abort");
    a = 8'hAA; b = 8'h77; cin = 1'b1; op_sub_drv = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({start_ready, done_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL abort state: got rdy=%b dv=%b busy=%b cout=%b sum=%h, expected 1/0/0/0/00",
               start_ready, done_valid, busy, cout, sum);
    end
    for (int i = 0; i < 2 * W; i++) begin
      if (done_valid) seen++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort pulse: got %0d done_valid cycles, expected 0", seen);
    end
  endtask

`ifdef SUB_MODE_EN
  task automatic test_sub();
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 9'h1F0, 0, "sub_10_20");
    run_op(8'h20, 8'h10, 1'b1, 1'b1, 9'h00F, 0, "sub_20_10_b");
    run_op(8'h20, 8'h10, 1'b1, 1'b0, 9'h031, 0, "add_after_sub");
  endtask
`endif

  initial begin
    rst = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub_drv = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
`ifdef SUB_MODE_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
